// File: rtl/nonce_scanner.sv
// Proof-of-work nonce sweep: hashes nonces 0..255 and asks an external 8-bit
// magnitude comparator whether hash < target; reports the first winner or exhaustion.
module nonce_scanner #(
  parameter logic [7:0] KEY = 8'h5B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] block_data,
  input  logic [7:0] target,
  output logic [7:0] cmp_a,
  output logic [7:0] cmp_b,
  input  logic       cmp_equal,
  input  logic       cmp_greater,
  input  logic       cmp_less,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [7:0] nonce,
  output logic [7:0] hash,
  output logic       err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HASH  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [7:0] cnt, data_r, target_r, hash_r;
  logic       flags_ok;

  function automatic logic [7:0] hash_fn(input logic [7:0] n, input logic [7:0] d);
    logic [7:0] x;
    x = n ^ d;
    return {x[4:0], x[7:5]} + KEY;
  endfunction

  // Operands are driven straight from registers so they are stable throughout CHECK.
  assign cmp_a = hash_r;
  assign cmp_b = target_r;

  always_comb begin
    flags_ok = 1'b0;
    case ({cmp_equal, cmp_greater, cmp_less})
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      data_r   <= '0;
      target_r <= '0;
      hash_r   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      nonce    <= '0;
      hash     <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data_r   <= block_data;
            target_r <= target;
            cnt      <= '0;
            found    <= 1'b0;
            nonce    <= '0;
            hash     <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= HASH;
          end
        end
        HASH: begin
          hash_r <= hash_fn(cnt, data_r);
          state  <= CHECK;
        end
        CHECK: begin
          // Strict acceptance: an equal hash does not win.
          if (!flags_ok) begin
            err   <= 1'b1;
            found <= 1'b0;
            nonce <= cnt;
            hash  <= hash_r;
            done  <= 1'b1;
            state <= DONE;
          end else if (cmp_less) begin
            found <= 1'b1;
            nonce <= cnt;
            hash  <= hash_r;
            done  <= 1'b1;
            state <= DONE;
          end else if (cnt == 8'hFF) begin
            found <= 1'b0;
            nonce <= 8'hFF;
            hash  <= hash_r;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt   <= cnt + 8'd1;
            state <= HASH;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_scanner.sv
// Directed bench for nonce_scanner with a behavioural comparator model that can
// be forced to emit all-zero flags.
module tb_nonce_scanner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] block_data = '0;
  logic [7:0] target = '0;
  logic [7:0] cmp_a, cmp_b;
  logic       cmp_equal, cmp_greater, cmp_less;
  logic       busy, done, found, err;
  logic [7:0] nonce, hash;
  logic       force_zero = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         dcyc, bcnt;

  always #5 clk = ~clk;

  assign cmp_equal   = force_zero ? 1'b0 : (cmp_a == cmp_b);
  assign cmp_greater = force_zero ? 1'b0 : (cmp_a >  cmp_b);
  assign cmp_less    = force_zero ? 1'b0 : (cmp_a <  cmp_b);

  nonce_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block_data(block_data), .target(target),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_equal(cmp_equal), .cmp_greater(cmp_greater),
    .cmp_less(cmp_less), .busy(busy), .done(done), .found(found), .nonce(nonce),
    .hash(hash), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call from inside an IDLE cycle (after #1 or at negedge). Returns at the
  // negedge of the done cycle; dcyc = -1 if done never arrived.
  task automatic scan(input logic [7:0] d, input logic [7:0] t, input int stray,
                      output int dc, output int bc);
    int cyc;
    block_data = d; target = t; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1; dc = -1; bc = 0;
    while (cyc < 600) begin
      @(negedge clk);
      if (cyc == stray) start = 1'b1;
      if (busy) bc++;
      if (done) begin dc = cyc; break; end
      @(posedge clk); #1 start = 1'b0;
      cyc++;
    end
  endtask

  task automatic idle_after(input string tag);
    @(posedge clk); #1;
    chk({tag, "_busy_low"}, busy, 1'b0);
    chk({tag, "_done_low"}, done, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_found", found, 0);
    chk("rst_err", err, 0); chk("rst_nonce", nonce, 8'h00); chk("rst_hash", hash, 8'h00);
    chk("rst_cmp_a", cmp_a, 8'h00); chk("rst_cmp_b", cmp_b, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Non-one-hot flags at the first check
    force_zero = 1'b1;
    scan(8'h00, 8'hFF, 0, dcyc, bcnt);
    chk("err_done_cyc", dcyc, 3); chk("err_flag", err, 1); chk("err_found", found, 0);
    chk("err_nonce", nonce, 8'h00); chk("err_hash", hash, 8'h5B);
    force_zero = 1'b0;
    idle_after("err");

    // Best case: nonce 0 wins immediately
    scan(8'h00, 8'hFF, 0, dcyc, bcnt);
    chk("best_done_cyc", dcyc, 3); chk("best_found", found, 1); chk("best_nonce", nonce, 8'h00);
    chk("best_hash", hash, 8'h5B); chk("best_err_cleared", err, 0); chk("best_busy_cycles", bcnt, 3);
    idle_after("best");
    repeat (3) @(posedge clk);
    #1 chk("best_hold_nonce", nonce, 8'h00); chk("best_hold_found", found, 1);

    // Equal hash at nonce 0 must not win; first strict win is nonce 0x15
    scan(8'h00, 8'h5B, 0, dcyc, bcnt);
    chk("eq_done_cyc", dcyc, 45); chk("eq_found", found, 1); chk("eq_nonce", nonce, 8'h15);
    chk("eq_hash", hash, 8'h03); chk("eq_cmp_b", cmp_b, 8'h5B);
    idle_after("eq");

    // target 0 exhausts; stray start at cycle 10 is ignored
    scan(8'h00, 8'h00, 10, dcyc, bcnt);
    chk("exh_done_cyc", dcyc, 513); chk("exh_found", found, 0); chk("exh_nonce", nonce, 8'hFF);
    chk("exh_hash", hash, 8'h5A); chk("exh_busy_cycles", bcnt, 513);
    idle_after("exh");

    // Restart in the first IDLE cycle after DONE
    scan(8'h00, 8'hFF, 0, dcyc, bcnt);
    chk("restart_done_cyc", dcyc, 3); chk("restart_nonce", nonce, 8'h00); chk("restart_found", found, 1);
    idle_after("restart");

    // Asynchronous reset mid-scan
    block_data = 8'h00; target = 8'h00; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (99) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_found", found, 0); chk("arst_nonce", nonce, 0);
    chk("arst_cmp_a", cmp_a, 0); chk("arst_cmp_b", cmp_b, 0); chk("arst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    scan(8'h00, 8'hFF, 0, dcyc, bcnt);
    chk("post_rst_done_cyc", dcyc, 3); chk("post_rst_nonce", nonce, 8'h00);
    chk("post_rst_hash", hash, 8'h5B);
    idle_after("post_rst");

    // Nonzero data: n=0 -> rotl3(A5)=2D, +5B = 88 >= 80; n=1 -> rotl3(A4)=25, +5B = 80 (equal);
    // n=2 -> rotl3(A7)=3D, +5B = 98; n=3 -> rotl3(A6)=35, +5B = 90; n=4 -> rotl3(A1)=0D, +5B = 68 wins
    scan(8'hA5, 8'h80, 0, dcyc, bcnt);
    chk("data_done_cyc", dcyc, 11); chk("data_nonce", nonce, 8'h04); chk("data_hash", hash, 8'h68);
    idle_after("data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nonce_scanner.md
# nonce_scanner

Sequential proof-of-work search engine that drives the 8-bit magnitude comparator from the requesting side. It produces operands (`cmp_a`, `cmp_b`) and consumes the comparator's `equal`/`greater`/`less` flags. On `start` it sweeps nonces 0..255, computes a toy 8-bit hash per nonce, and asks the external comparator whether hash < target. It reports the first winning nonce, or exhaustion, with a one-cycle `done` pulse. It sits between the mining control logic and the comparator instance.

## Interface
- `KEY`, 8'h5B: additive mixing constant of the hash.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a scan; sampled only in IDLE.
- `block_data`  in  8  block payload; latched when `start` is accepted.
- `target`  in  8  difficulty target; latched when `start` is accepted.
- `cmp_a`  out  8  comparator operand a; equals registered hash `hash_r`.
- `cmp_b`  out  8  comparator operand b; equals registered target `target_r`.
- `cmp_equal`  in  1  comparator flag, a == b.
- `cmp_greater`  in  1  comparator flag, a > b.
- `cmp_less`  in  1  comparator flag, a < b.
- `busy`  out  1  high while a scan is in progress (HASH, CHECK, DONE).
- `done`  out  1  one-cycle pulse when the result is valid.
- `found`  out  1  a winning nonce was found.
- `nonce`  out  8  winning nonce, or 8'hFF on exhaustion.
- `hash`  out  8  hash of the reported nonce.
- `err`  out  1  comparator flags were not one-hot during a check.

## Operation
- Hash function: h(n) = rotl3(n ^ data_r) + KEY, modulo 256.
  - rotl3 is an 8-bit rotate left by 3.
  - Carry out of the addition is discarded.
- FSM states: IDLE, HASH, CHECK, DONE.
- IDLE, `start`=1:
  - Latch `data_r`, `target_r`.
  - Set `cnt`=0.
  - Clear `found`, `nonce`, `hash`, `err`.
  - Go to HASH.
- IDLE, `start`=0: stay in IDLE.
- HASH: register `hash_r` = h(`cnt`); go to CHECK.
- CHECK: comparator compares `cmp_a`=`hash_r` against `cmp_b`=`target_r`, combinationally in the same cycle. Evaluate in this priority order:
  1. Flags not exactly one-hot: set `err`=1, `found`=0, `nonce`=`cnt`, `hash`=`hash_r`; go to DONE.
  2. `cmp_less`=1: set `found`=1, `nonce`=`cnt`, `hash`=`hash_r`; go to DONE.
  3. `cnt`==8'hFF: set `found`=0, `nonce`=8'hFF, `hash`=`hash_r`; go to DONE.
  4. Otherwise: `cnt`+1; go to HASH.
- Acceptance is strict: `cmp_equal` does not win.
  - `target`=0 can never be met and always exhausts.
- DONE: `done`=1 for exactly this cycle; go to IDLE.
- `start` is ignored in HASH, CHECK and DONE; there is no queueing.
- `found`, `nonce`, `hash`, `err` hold their values until the next accepted `start`.
- Reset, including mid-scan: every register returns to its reset value immediately, and the FSM goes to IDLE.

## Timing
- Reset values:
  - `busy`, `done`, `found`, `err` = 0.
  - `nonce`, `hash`, `cmp_a`, `cmp_b` = 8'h00.
  - `cnt`, `data_r`, `target_r`, `hash_r` = 0.
  - State = IDLE.
- Cycle 0 is the edge where `start` is sampled high in IDLE.
- Nonce n is hashed in cycle 2n+1 and checked in cycle 2n+2.
- Result and `done` appear in cycle 2n+3.
  - Best case (win on nonce 0): 3 cycles.
  - Exhaustion: cycle 513.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- A new `start` can be accepted in the first IDLE cycle after DONE.
- All outputs are registered; `cmp_a`/`cmp_b` are stable throughout CHECK.

## Test plan
- KEY=5B, data=00, target=FF, pulse start → `done` at cycle 3, `found`=1, `nonce`=00, `hash`=5B, `err`=0.
- data=00, target=5B → `done` at cycle 45, `found`=1, `nonce`=15, `hash`=03. Nonce 0 gives hash 5B, which is equal and must not win.
- data=00, target=00 → `done` at cycle 513, `found`=0, `nonce`=FF, `hash`=5A; `busy` high cycles 1–513.
- Comparator flags forced to 000 → at first CHECK (cycle 2): `err`=1, `found`=0, `nonce`=00, `done` at cycle 3.
- Start pulse at cycle 10 of the target=00 scan → ignored; the scan completes normally at 513. A new start in the following IDLE cycle is accepted.
- `rst_n` low at cycle 100 of the target=00 scan → all outputs 0 asynchronously. After release, start with target=FF → `done` 3 cycles later with `nonce`=00.
